traffic_ctrl_multi: RTL and testbench
=====================================

# traffic_ctrl_multi

Parametrised multi-approach traffic-light controller, the successor to the single-signal four-state controller. It drives NUM_DIR signal heads and grants green to one approach at a time in round-robin order. Approaches with no demand are skipped. Every handover goes through an all-red clearance phase. An optional night flashing mode is included. It sits at the top of the intersection subsystem and feeds the lamp drivers directly.

## Interface
- NUM_DIR, 2 — number of approaches; must be ≥2.
- CNT_W, 10 — phase counter width; must hold max(T_*)−1.
- T_RED_YELLOW, 3 — cycles in the red+yellow phase; must be ≥1.
- T_GREEN, 3 — cycles in green; must be ≥1.
- T_YELLOW, 3 — cycles in yellow; must be ≥1.
- T_ALL_RED, 2 — cycles in all-red clearance; must be ≥1.
- T_FLASH, 4 — cycles per flash half-period; must be ≥1.
- DIR_W, $clog2(NUM_DIR) — derived; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- demand_i  in  NUM_DIR  per-approach vehicle/pedestrian demand, level
- flash_i  in  1  request night flashing mode, level
- red_o  out  NUM_DIR  red lamp per approach
- yellow_o  out  NUM_DIR  yellow lamp per approach
- green_o  out  NUM_DIR  green lamp per approach
- active_dir_o  out  DIR_W  approach currently or last served
- phase_o  out  3  current phase encoding, for debug and status

## Operation
- State register holds the phase, active_dir and phase counter cnt.
- Phases are S_ALL_RED, S_RED_YELLOW, S_GREEN, S_YELLOW and S_FLASH.
- Each phase lasts exactly its T_* cycles. cnt runs 0..T−1; at cnt==T−1 the phase advances and cnt returns to 0. Compare is equality on CNT_W bits.
- Normal sequence: S_ALL_RED → S_RED_YELLOW → S_GREEN → S_YELLOW → S_ALL_RED.
- active_dir changes only on the S_ALL_RED→S_RED_YELLOW transition.
- Next-approach selection happens in the last S_ALL_RED cycle, using demand_i sampled in that cycle:
  - Search circularly from active_dir+1 (mod NUM_DIR) and take the first approach with demand.
  - If there is no demand anywhere, take active_dir+1 (fixed-time fallback).
  - The current approach is eligible again only after the search wraps to it.
- Lamp decode, combinational from registered state:
  - Active approach: S_RED_YELLOW drives red+yellow, S_GREEN drives green, S_YELLOW drives yellow.
  - All non-active approaches show red only.
  - S_ALL_RED drives every red.
  - At most one green_o bit is ever set.
- Reset values: phase S_ALL_RED, cnt 0, active_dir NUM_DIR−1 (so approach 0 is searched first), red_o all ones, yellow_o 0, green_o 0, phase_o S_ALL_RED.
- Reset mid-operation takes effect on the next edge from any phase, including green or flash. No yellow is inserted.
- Demand changes outside the last S_ALL_RED cycle have no effect.

## Timing
- With demand present, one approach occupies T_RED_YELLOW+T_GREEN+T_YELLOW+T_ALL_RED cycles.
- After rst drops there are T_ALL_RED cycles of all-red before the first S_RED_YELLOW.
- Inputs affect outputs with a latency of one clock: decision in cycle n, new lamps visible from cycle n+1.
- If flash entry and a next-approach decision coincide (last S_ALL_RED cycle with flash_i=1), flash wins and active_dir is unchanged.

## Configuration
- Macro TRAFFIC_CTRL_FLASH_EN.
- Defined:
  - flash_i is honoured only at the end of S_ALL_RED. The current green always completes its yellow and all-red first.
  - In S_FLASH, red_o=0 and green_o=0. yellow_o is all ones or all zeros, toggling every T_FLASH cycles and starting with ones.
  - When flash_i is low in any S_FLASH cycle, the next phase is S_ALL_RED with cnt=0, for a full T_ALL_RED.
- Undefined:
  - flash_i is ignored and S_FLASH is unreachable.
  - The flash toggle register and its logic are absent.
  - Phase encoding is unchanged.

## Structure
- Package traffic_ctrl_pkg holds the t_phase enum (3-bit; S_ALL_RED=0, S_RED_YELLOW=1, S_GREEN=2, S_YELLOW=3, S_FLASH=4) and the default T_* constants.
- Sub-module rr_next_dir: combinational circular priority search with parameter NUM_DIR.
  - Inputs: demand, current dir.
  - Output: next dir.
- The phase counter stays inline.

## Test plan
Bench settings: NUM_DIR=3, T_RED_YELLOW=1, T_GREEN=4, T_YELLOW=2, T_ALL_RED=2, T_FLASH=3, demand_i=3'b111.

- Reset release → cycles 0–1 all red; cycle 2 dir0 red+yellow; cycles 3–6 green_o=3'b001; cycles 7–8 yellow_o=3'b001; 9–10 all red; cycle 11 active_dir_o=1.
- demand_i=3'b100 held from reset → approach 2 is served every 9 cycles; approaches 0/1 are never green. With demand_i=0, the order is 0,1,2,0.
- Sweep demand 3'b010→3'b001 changed mid-green of dir1 → the next approach is decided at the last all-red cycle and is 0.
- rst asserted in the 2nd green cycle → next cycle red_o=3'b111, green_o=0; the restart repeats scenario 1 timing.
- TRAFFIC_CTRL_FLASH_EN defined, flash_i raised in dir0 green → green/yellow/all-red complete; yellow_o alternates 3'b111/000 every 3 cycles. flash_i dropped → 2 all-red cycles, then dir1 red+yellow.
- TRAFFIC_CTRL_FLASH_EN undefined, flash_i=1 → output sequence identical to scenario 1.

Source files
------------

// File: rtl/traffic_ctrl_pkg.sv
// Shared types and default timing for the multi-approach traffic controller.
// The phase encoding is fixed; S_FLASH exists even when flashing is compiled out.
package traffic_ctrl_pkg;

    typedef enum logic [2:0] {
        S_ALL_RED    = 3'd0,
        S_RED_YELLOW = 3'd1,
        S_GREEN      = 3'd2,
        S_YELLOW     = 3'd3,
        S_FLASH      = 3'd4
    } t_phase;

    localparam int NUM_DIR_DEF      = 2;
    localparam int CNT_W_DEF        = 10;
    localparam int T_RED_YELLOW_DEF = 3;
    localparam int T_GREEN_DEF      = 3;
    localparam int T_YELLOW_DEF     = 3;
    localparam int T_ALL_RED_DEF    = 2;
    localparam int T_FLASH_DEF      = 4;

endpackage

// File: rtl/traffic_ctrl_multi_rr_next_dir.sv
// Circular priority search: first approach with demand after the current one,
// falling back to current+1 when nobody is waiting.
module rr_next_dir #(
    parameter  int NUM_DIR = 2,
    localparam int DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] i_demand,
    input  logic [DIR_W-1:0]   i_cur_dir,
    output logic [DIR_W-1:0]   o_next_dir
);

    function automatic logic [DIR_W-1:0] step(input logic [DIR_W-1:0] d, input int k);
        int s;
        s = (int'(d) + k) % NUM_DIR;
        return DIR_W'(s);
    endfunction

    // Scan from farthest to nearest so the nearest requester overrides the rest;
    // the current approach (k == NUM_DIR) has the lowest priority.
    always_comb begin
        o_next_dir = step(i_cur_dir, 1);
        for (int k = NUM_DIR; k >= 1; k--) begin
            o_next_dir = i_demand[step(i_cur_dir, k)] ? step(i_cur_dir, k) : o_next_dir;
        end
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin multi-approach traffic-light controller with all-red clearance.
// Optional night flashing mode is built when TRAFFIC_CTRL_FLASH_EN is defined.
module traffic_ctrl_multi
    import traffic_ctrl_pkg::*;
#(
    parameter  int NUM_DIR      = NUM_DIR_DEF,
    parameter  int CNT_W        = CNT_W_DEF,
    parameter  int T_RED_YELLOW = T_RED_YELLOW_DEF,
    parameter  int T_GREEN      = T_GREEN_DEF,
    parameter  int T_YELLOW     = T_YELLOW_DEF,
    parameter  int T_ALL_RED    = T_ALL_RED_DEF,
    parameter  int T_FLASH      = T_FLASH_DEF,
    localparam int DIR_W        = $clog2(NUM_DIR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DIR-1:0] demand_i,
    input  logic               flash_i,
    output logic [NUM_DIR-1:0] red_o,
    output logic [NUM_DIR-1:0] yellow_o,
    output logic [NUM_DIR-1:0] green_o,
    output logic [DIR_W-1:0]   active_dir_o,
    output logic [2:0]         phase_o
);

    t_phase             r_phase;
    t_phase             w_phase_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_tlim;
    logic               w_last;
    logic [DIR_W-1:0]   r_dir;
    logic [DIR_W-1:0]   w_dir_nxt;
    logic [DIR_W-1:0]   w_rr_dir;
    logic [NUM_DIR-1:0] w_dir_oh;

`ifdef TRAFFIC_CTRL_FLASH_EN
    logic r_flash_yel;
    logic w_flash_yel_nxt;
`else
    logic w_unused_flash;
    assign w_unused_flash = flash_i;
`endif

    rr_next_dir #(
        .NUM_DIR (NUM_DIR)
    ) u_rr_next_dir (
        .i_demand   (demand_i),
        .i_cur_dir  (r_dir),
        .o_next_dir (w_rr_dir)
    );

    // Last count value of the current phase.
    always_comb begin
        case (r_phase)
            S_ALL_RED:    w_tlim = CNT_W'(T_ALL_RED - 1);
            S_RED_YELLOW: w_tlim = CNT_W'(T_RED_YELLOW - 1);
            S_GREEN:      w_tlim = CNT_W'(T_GREEN - 1);
            S_YELLOW:     w_tlim = CNT_W'(T_YELLOW - 1);
            S_FLASH:      w_tlim = CNT_W'(T_FLASH - 1);
            default:      w_tlim = {CNT_W{1'b0}};
        endcase
    end

    assign w_last = (r_cnt == w_tlim);

    // Phase sequencing; the next approach is only chosen at the end of all-red.
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = w_last ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
        w_dir_nxt   = r_dir;
`ifdef TRAFFIC_CTRL_FLASH_EN
        w_flash_yel_nxt = r_flash_yel;
`endif
        case (r_phase)
            S_ALL_RED: begin
                if (w_last) begin
`ifdef TRAFFIC_CTRL_FLASH_EN
                    if (flash_i) begin
                        w_phase_nxt     = S_FLASH;
                        w_flash_yel_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = S_RED_YELLOW;
                        w_dir_nxt   = w_rr_dir;
                    end
`else
                    w_phase_nxt = S_RED_YELLOW;
                    w_dir_nxt   = w_rr_dir;
`endif
                end else begin
                    w_phase_nxt = S_ALL_RED;
                end
            end
            S_RED_YELLOW: w_phase_nxt = w_last ? S_GREEN   : S_RED_YELLOW;
            S_GREEN:      w_phase_nxt = w_last ? S_YELLOW  : S_GREEN;
            S_YELLOW:     w_phase_nxt = w_last ? S_ALL_RED : S_YELLOW;
`ifdef TRAFFIC_CTRL_FLASH_EN
            S_FLASH: begin
                if (!flash_i) begin
                    w_phase_nxt = S_ALL_RED;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_phase_nxt     = S_FLASH;
                    w_flash_yel_nxt = w_last ? ~r_flash_yel : r_flash_yel;
                end
            end
`endif
            default: begin
                w_phase_nxt = S_ALL_RED;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register; reset parks on the last approach so approach 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= S_ALL_RED;
            r_cnt   <= {CNT_W{1'b0}};
            r_dir   <= DIR_W'(NUM_DIR - 1);
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

`ifdef TRAFFIC_CTRL_FLASH_EN
    // Flash half-period lamp state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flash_yel <= 1'b0;
        end else begin
            r_flash_yel <= w_flash_yel_nxt;
        end
    end
`endif

    assign w_dir_oh = {{(NUM_DIR - 1){1'b0}}, 1'b1} << r_dir;

    // Lamp decode: non-active approaches always see red, only the active one gets green.
    always_comb begin
        red_o    = {NUM_DIR{1'b1}};
        yellow_o = {NUM_DIR{1'b0}};
        green_o  = {NUM_DIR{1'b0}};
        case (r_phase)
            S_ALL_RED:    red_o = {NUM_DIR{1'b1}};
            S_RED_YELLOW: yellow_o = w_dir_oh;
            S_GREEN: begin
                red_o   = ~w_dir_oh;
                green_o = w_dir_oh;
            end
            S_YELLOW: begin
                red_o    = ~w_dir_oh;
                yellow_o = w_dir_oh;
            end
`ifdef TRAFFIC_CTRL_FLASH_EN
            S_FLASH: begin
                red_o    = {NUM_DIR{1'b0}};
                yellow_o = {NUM_DIR{r_flash_yel}};
            end
`endif
            default: red_o = {NUM_DIR{1'b1}};
        endcase
    end

    assign active_dir_o = r_dir;
    assign phase_o      = r_phase;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed, table-driven bench for traffic_ctrl_multi (3 approaches, short timers).
module tb_traffic_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] demand;
    logic       flash;
    logic [2:0] red, yel, grn;
    logic [1:0] dir;
    logic [2:0] ph;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_ctrl_multi #(
        .NUM_DIR      (3),
        .CNT_W        (10),
        .T_RED_YELLOW (1),
        .T_GREEN      (4),
        .T_YELLOW     (2),
        .T_ALL_RED    (2),
        .T_FLASH      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .demand_i     (demand),
        .flash_i      (flash),
        .red_o        (red),
        .yellow_o     (yel),
        .green_o      (grn),
        .active_dir_o (dir),
        .phase_o      (ph)
    );

    // chk: compare outputs seen this cycle; rst/dem/fl: inputs driven during this cycle
    typedef struct {
        bit         chk;
        bit         rst;
        logic [2:0] dem;
        bit         fl;
        logic [2:0] red;
        logic [2:0] yel;
        logic [2:0] grn;
        logic [1:0] dir;
        logic [2:0] ph;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit c, input bit r, input logic [2:0] d, input bit f,
                     input logic [2:0] er, input logic [2:0] ey, input logic [2:0] eg,
                     input logic [1:0] ed, input logic [2:0] ep);
        vec_t t;
        t.chk = c; t.rst = r; t.dem = d; t.fl = f;
        t.red = er; t.yel = ey; t.grn = eg; t.dir = ed; t.ph = ep;
        tbl.push_back(t);
    endtask

    task automatic cmp(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at step %0d: got %0h, expected %0h", nm, row, got, exp);
        end
    endtask

    // Scenario 1 rows: reset release with demand everywhere; f is flash_i throughout.
    task automatic add_basic(input bit f);
        v(0, 1, 3'b111, f, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b111, f, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c0
        v(1, 0, 3'b111, f, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c1
        v(1, 0, 3'b111, f, 3'b111, 3'b001, 3'b000, 2'd0, 3'd1); // c2
        for (int i = 3; i <= 6; i++)
            v(1, 0, 3'b111, f, 3'b110, 3'b000, 3'b001, 2'd0, 3'd2);
        for (int i = 7; i <= 8; i++)
            v(1, 0, 3'b111, f, 3'b110, 3'b001, 3'b000, 2'd0, 3'd3);
        for (int i = 9; i <= 10; i++)
            v(1, 0, 3'b111, f, 3'b111, 3'b000, 3'b000, 2'd0, 3'd0);
        v(1, 0, 3'b111, f, 3'b111, 3'b010, 3'b000, 2'd1, 3'd1); // c11
        v(1, 0, 3'b111, f, 3'b101, 3'b000, 3'b010, 2'd1, 3'd2); // c12
    endtask

    initial begin
        rst    = 1'b1;
        demand = 3'b111;
        flash  = 1'b0;

        add_basic(1'b0);

        // Reset in the 2nd green cycle, then the same timing restarts.
        v(0, 1, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c0
        v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c1
        v(1, 0, 3'b111, 0, 3'b111, 3'b001, 3'b000, 2'd0, 3'd1); // c2
        v(1, 0, 3'b111, 0, 3'b110, 3'b000, 3'b001, 2'd0, 3'd2); // c3
        v(1, 1, 3'b111, 0, 3'b110, 3'b000, 3'b001, 2'd0, 3'd2); // c4, rst asserted
        v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // restart c0
        v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b111, 0, 3'b111, 3'b001, 3'b000, 2'd0, 3'd1);
        for (int i = 0; i < 4; i++)
            v(1, 0, 3'b111, 0, 3'b110, 3'b000, 3'b001, 2'd0, 3'd2);
        for (int i = 0; i < 2; i++)
            v(1, 0, 3'b111, 0, 3'b110, 3'b001, 3'b000, 2'd0, 3'd3);
        for (int i = 0; i < 2; i++)
            v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd0, 3'd0);
        v(1, 0, 3'b111, 0, 3'b111, 3'b010, 3'b000, 2'd1, 3'd1);

        // Demand only on approach 2 from reset.
        v(0, 1, 3'b100, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b100, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b100, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b100, 0, 3'b111, 3'b100, 3'b000, 2'd2, 3'd1);
        for (int i = 0; i < 4; i++)
            v(1, 0, 3'b100, 0, 3'b011, 3'b000, 3'b100, 2'd2, 3'd2);
        for (int i = 0; i < 2; i++)
            v(1, 0, 3'b100, 0, 3'b011, 3'b100, 3'b000, 2'd2, 3'd3);
        for (int i = 0; i < 2; i++)
            v(1, 0, 3'b100, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b100, 0, 3'b111, 3'b100, 3'b000, 2'd2, 3'd1);

        // Demand moves 010 -> 001 mid-green; only the last all-red cycle counts.
        v(0, 1, 3'b010, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b010, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c0
        v(1, 0, 3'b010, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c1
        v(1, 0, 3'b010, 0, 3'b111, 3'b010, 3'b000, 2'd1, 3'd1); // c2
        v(1, 0, 3'b010, 0, 3'b101, 3'b000, 3'b010, 2'd1, 3'd2); // c3
        for (int i = 4; i <= 6; i++)
            v(1, 0, 3'b001, 0, 3'b101, 3'b000, 3'b010, 2'd1, 3'd2);
        for (int i = 7; i <= 8; i++)
            v(1, 0, 3'b001, 0, 3'b101, 3'b010, 3'b000, 2'd1, 3'd3);
        v(1, 0, 3'b100, 0, 3'b111, 3'b000, 3'b000, 2'd1, 3'd0); // c9 first all-red
        v(1, 0, 3'b001, 0, 3'b111, 3'b000, 3'b000, 2'd1, 3'd0); // c10 decision
        v(1, 0, 3'b010, 0, 3'b111, 3'b001, 3'b000, 2'd0, 3'd1); // c11
        v(1, 0, 3'b010, 0, 3'b110, 3'b000, 3'b001, 2'd0, 3'd2); // c12

`ifdef TRAFFIC_CTRL_FLASH_EN
        // Flash requested during dir0 green: clearance completes, then flashing.
        v(0, 1, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0);
        v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c0
        v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd2, 3'd0); // c1
        v(1, 0, 3'b111, 0, 3'b111, 3'b001, 3'b000, 2'd0, 3'd1); // c2
        v(1, 0, 3'b111, 0, 3'b110, 3'b000, 3'b001, 2'd0, 3'd2); // c3
        for (int i = 4; i <= 6; i++)
            v(1, 0, 3'b111, 1, 3'b110, 3'b000, 3'b001, 2'd0, 3'd2);
        for (int i = 7; i <= 8; i++)
            v(1, 0, 3'b111, 1, 3'b110, 3'b001, 3'b000, 2'd0, 3'd3);
        for (int i = 9; i <= 10; i++)
            v(1, 0, 3'b111, 1, 3'b111, 3'b000, 3'b000, 2'd0, 3'd0);
        for (int i = 11; i <= 13; i++)
            v(1, 0, 3'b111, 1, 3'b000, 3'b111, 3'b000, 2'd0, 3'd4);
        for (int i = 14; i <= 16; i++)
            v(1, 0, 3'b111, 1, 3'b000, 3'b000, 3'b000, 2'd0, 3'd4);
        for (int i = 17; i <= 18; i++)
            v(1, 0, 3'b111, 1, 3'b000, 3'b111, 3'b000, 2'd0, 3'd4);
        v(1, 0, 3'b111, 0, 3'b000, 3'b111, 3'b000, 2'd0, 3'd4); // c19 flash dropped
        for (int i = 20; i <= 21; i++)
            v(1, 0, 3'b111, 0, 3'b111, 3'b000, 3'b000, 2'd0, 3'd0);
        v(1, 0, 3'b111, 0, 3'b111, 3'b010, 3'b000, 2'd1, 3'd1); // c22
`else
        // Flash compiled out: flash_i high must not change the basic sequence.
        add_basic(1'b1);
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            if (tbl[i].chk) begin
                cmp("red_o",        i, 32'(red), 32'(tbl[i].red));
                cmp("yellow_o",     i, 32'(yel), 32'(tbl[i].yel));
                cmp("green_o",      i, 32'(grn), 32'(tbl[i].grn));
                cmp("active_dir_o", i, 32'(dir), 32'(tbl[i].dir));
                cmp("phase_o",      i, 32'(ph),  32'(tbl[i].ph));
            end
            rst    = tbl[i].rst;
            demand = tbl[i].dem;
            flash  = tbl[i].fl;
        end

        // No demand at all: fixed-time rotation 0,1,2,0.
        begin
            int exp_d[4];
            exp_d = '{0, 1, 2, 0};
            rst = 1'b1; demand = 3'b000; flash = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            for (int c = 1; c <= 29; c++) begin
                @(negedge clk);
                if (c % 9 == 2) begin
                    cmp("fallback_dir",   c, 32'(dir), 32'(exp_d[c / 9]));
                    cmp("fallback_phase", c, 32'(ph),  32'(1));
                end
            end
        end

        // Demand only on approach 2 over several rounds: 0/1 never green.
        rst = 1'b1; demand = 3'b100;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            cmp("no_green_01", c, 32'(grn & 3'b011), 32'(0));
            if (c % 9 == 2) begin
                cmp("only2_dir",   c, 32'(dir), 32'(2));
                cmp("only2_phase", c, 32'(ph),  32'(1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
